// File: rtl/arima_cfg_loader_pkg.sv
// -----------------------------------------------------------------------------
// arima_pkg
//   Shared constants and types for the ARIMA configuration loader.
//   MAX_ORDER : maximum AR/MA order and coefficient bank depth
//   DATA_W    : config word / coefficient width (signed Q16.15)
//   FRAC_W    : fractional bits of a coefficient
//   HDR_TAG   : tag byte that marks a well-formed header word
//   state_e   : loader FSM states
//   hdr_valid : header sanity check (tag, order limits, d <= 3)
// -----------------------------------------------------------------------------
package arima_pkg;

  localparam int           MAX_ORDER = 10;
  localparam int           DATA_W    = 32;
  localparam int           FRAC_W    = 15;
  localparam logic [7:0]   HDR_TAG   = 8'hA5;
  localparam logic [7:0]   MAX_D     = 8'd3;

  typedef enum logic [2:0] {
    S_HDR   = 3'd0,
    S_CONT  = 3'd1,
    S_AR    = 3'd2,
    S_MA    = 3'd3,
    S_START = 3'd4,
    S_ERR   = 3'd5
  } state_e;

  // Header layout: [7:0]=p, [15:8]=d, [23:16]=q, [31:24]=tag.
  function automatic logic hdr_valid(input logic [31:0] w, input logic [7:0] max_ord);
    return (w[31:24] == HDR_TAG) &&
           (w[7:0]   <= max_ord) &&
           (w[23:16] <= max_ord) &&
           (w[15:8]  <= MAX_D);
  endfunction

endpackage

// File: rtl/arima_cfg_loader_if.sv
// -----------------------------------------------------------------------------
// arima_cfg_loader_if
//   Config word stream into the loader (valid/ready handshake).
//   cfg_valid : word present on cfg_data
//   cfg_first : marks cfg_data as a frame header
//   cfg_data  : config word
//   cfg_ready : loader accepts a word this cycle
//   master drives the stream, slave is the loader.
// -----------------------------------------------------------------------------
interface arima_cfg_loader_if #(
  parameter int DATA_W = arima_pkg::DATA_W
);

  logic              cfg_valid;
  logic              cfg_first;
  logic [DATA_W-1:0] cfg_data;
  logic              cfg_ready;

  modport master (
    output cfg_valid,
    output cfg_first,
    output cfg_data,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_first,
    input  cfg_data,
    output cfg_ready
  );

endinterface

// File: rtl/arima_cfg_loader.sv
// -----------------------------------------------------------------------------
// arima_cfg_loader
//   Parses a configuration frame (header, cont, p AR coefs, q MA coefs) into a
//   shadow bank and commits it atomically to the output bank, pulsing start.
//   A header seen mid-frame aborts the frame and restarts parsing; a bad header
//   parks the loader in S_ERR with a sticky cfg_err until a good header.
//
//   clk, rst_n         : clock, async active-low reset
//   cfg                : config stream (slave side)
//   p/d/q_order, cont  : committed orders and cont word
//   ar_coef, ma_coef   : committed coefficients (unused slots are zero)
//   start              : one-cycle pulse in the cycle after a commit edge
//   cfg_err            : sticky, set by a rejected header
// -----------------------------------------------------------------------------
module arima_cfg_loader #(
  parameter int MAX_ORDER = arima_pkg::MAX_ORDER,
  parameter int DATA_W    = arima_pkg::DATA_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  arima_cfg_loader_if.slave        cfg,
  output logic [31:0]              p_order,
  output logic [31:0]              d_order,
  output logic [31:0]              q_order,
  output logic [31:0]              cont,
  output logic signed [DATA_W-1:0] ar_coef [MAX_ORDER],
  output logic signed [DATA_W-1:0] ma_coef [MAX_ORDER],
  output logic                     start,
  output logic                     cfg_err
);

  import arima_pkg::*;

  state_e state_q, state_d;

  logic [3:0]               idx_q, idx_d;
  logic [7:0]               p_sh_q, d_sh_q, q_sh_q;
  logic [DATA_W-1:0]        cont_sh_q, cont_sh_d;
  logic signed [DATA_W-1:0] ar_sh_q [MAX_ORDER];
  logic signed [DATA_W-1:0] ar_sh_d [MAX_ORDER];
  logic signed [DATA_W-1:0] ma_sh_q [MAX_ORDER];
  logic signed [DATA_W-1:0] ma_sh_d [MAX_ORDER];

  logic hs, hdr_hs, word_hs, hdr_ok, last_ar, last_ma, commit;

  assign hs      = cfg.cfg_valid & cfg.cfg_ready;
  assign hdr_hs  = hs &  cfg.cfg_first;
  assign word_hs = hs & ~cfg.cfg_first;
  assign hdr_ok  = hdr_valid(cfg.cfg_data[31:0], 8'(MAX_ORDER));
  // Orders are nonzero whenever these are consulted, so the subtraction is safe.
  assign last_ar = (idx_q == 4'(p_sh_q - 8'd1));
  assign last_ma = (idx_q == 4'(q_sh_q - 8'd1));
  // Commit on the edge that enters S_START, so outputs and start line up.
  assign commit  = (state_d == S_START) && (state_q != S_START);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking (=) here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_HDR;
    else        state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and word index
  // ---------------------------------------------------------------------------
  // NOTE: every variable gets a default at the top of the block; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (state_q == S_START) begin
      state_d = S_HDR;
    end else if (hdr_hs) begin
      // A header restarts parsing from any state that can handshake.
      state_d = hdr_ok ? S_CONT : S_ERR;
      idx_d   = '0;
    end else if (word_hs) begin
      unique case (state_q)
        S_CONT: begin
          idx_d = '0;
          if      (p_sh_q != 8'd0) state_d = S_AR;
          else if (q_sh_q != 8'd0) state_d = S_MA;
          else                     state_d = S_START;
        end
        S_AR: begin
          if (last_ar) begin
            idx_d   = '0;
            state_d = (q_sh_q != 8'd0) ? S_MA : S_START;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
        S_MA: begin
          if (last_ma) begin
            idx_d   = '0;
            state_d = S_START;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
        default: ; // S_HDR / S_ERR drop non-header words
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    cfg.cfg_ready = rst_n && (state_q != S_START);
    start         = (state_q == S_START);
  end

  // ---------------------------------------------------------------------------
  // Shadow bank next value
  // ---------------------------------------------------------------------------
  always_comb begin
    cont_sh_d = cont_sh_q;
    ar_sh_d   = ar_sh_q;
    ma_sh_d   = ma_sh_q;
    if (hdr_hs && hdr_ok) begin
      // Clearing the whole bank covers the slots above the new orders; the
      // lower slots are rewritten by the frame before any commit.
      for (int i = 0; i < MAX_ORDER; i++) begin
        ar_sh_d[i] = '0;
        ma_sh_d[i] = '0;
      end
    end else if (word_hs) begin
      unique case (state_q)
        S_CONT:  cont_sh_d      = cfg.cfg_data;
        S_AR:    ar_sh_d[idx_q] = cfg.cfg_data;
        S_MA:    ma_sh_d[idx_q] = cfg.cfg_data;
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Shadow and commit banks, error flag
  // ---------------------------------------------------------------------------
  // NOTE: the coefficient banks are reset element by element because a reset
  // must clear committed outputs and any half-loaded frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= '0;
      p_sh_q    <= '0;
      d_sh_q    <= '0;
      q_sh_q    <= '0;
      cont_sh_q <= '0;
      cfg_err   <= 1'b0;
      p_order   <= '0;
      d_order   <= '0;
      q_order   <= '0;
      cont      <= '0;
      for (int i = 0; i < MAX_ORDER; i++) begin
        ar_sh_q[i] <= '0;
        ma_sh_q[i] <= '0;
        ar_coef[i] <= '0;
        ma_coef[i] <= '0;
      end
    end else begin
      idx_q     <= idx_d;
      cont_sh_q <= cont_sh_d;
      ar_sh_q   <= ar_sh_d;
      ma_sh_q   <= ma_sh_d;
      if (hdr_hs) begin
        cfg_err <= ~hdr_ok;
        if (hdr_ok) begin
          p_sh_q <= cfg.cfg_data[7:0];
          d_sh_q <= cfg.cfg_data[15:8];
          q_sh_q <= cfg.cfg_data[23:16];
        end
      end
      // The final word never coincides with a header, so the orders are
      // already settled; cont/coefficients come from _d to include that word.
      if (commit) begin
        p_order <= 32'(p_sh_q);
        d_order <= 32'(d_sh_q);
        q_order <= 32'(q_sh_q);
        cont    <= 32'(cont_sh_d);
        ar_coef <= ar_sh_d;
        ma_coef <= ma_sh_d;
      end
    end
  end

endmodule

// File: tb/tb_arima_cfg_loader.sv
// -----------------------------------------------------------------------------
// tb_arima_cfg_loader
//   Directed self-checking bench for arima_cfg_loader.
// -----------------------------------------------------------------------------
module tb_arima_cfg_loader;

  localparam int MAXO   = 10;
  localparam int SNAP_W = 4 * 32 + 2 * MAXO * 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  arima_cfg_loader_if #(.DATA_W(32)) cfg_if ();

  logic [31:0]        p_order, d_order, q_order, cont;
  logic signed [31:0] ar_coef [MAXO];
  logic signed [31:0] ma_coef [MAXO];
  logic               start, cfg_err;

  arima_cfg_loader #(.MAX_ORDER(MAXO), .DATA_W(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cfg     (cfg_if),
    .p_order (p_order),
    .d_order (d_order),
    .q_order (q_order),
    .cont    (cont),
    .ar_coef (ar_coef),
    .ma_coef (ma_coef),
    .start   (start),
    .cfg_err (cfg_err)
  );

  int errors = 0;
  int checks = 0;

  // Event counters
  int hs_cnt    = 0;
  int start_cnt = 0;
  int ready_bad = 0;

  always @(posedge clk) if (rst_n && cfg_if.cfg_valid && cfg_if.cfg_ready) hs_cnt++;
  always @(negedge clk) begin
    if (start) start_cnt++;
    if (rst_n && !cfg_if.cfg_ready && !start) ready_bad++;
  end

  // Expected committed state
  logic [31:0]        exp_p, exp_d, exp_q, exp_cont;
  logic signed [31:0] exp_ar [MAXO];
  logic signed [31:0] exp_ma [MAXO];

  function automatic logic [SNAP_W-1:0] pack(input logic [31:0] p, input logic [31:0] d,
                                             input logic [31:0] q, input logic [31:0] c,
                                             input logic signed [31:0] ar [MAXO],
                                             input logic signed [31:0] ma [MAXO]);
    logic [SNAP_W-1:0] v;
    v = '0;
    v[127:0] = {p, d, q, c};
    for (int i = 0; i < MAXO; i++) begin
      v[128 + i*32 +: 32]          = ar[i];
      v[128 + (MAXO + i)*32 +: 32] = ma[i];
    end
    return v;
  endfunction

  function automatic logic [SNAP_W-1:0] dut_snap();
    return pack(p_order, d_order, q_order, cont, ar_coef, ma_coef);
  endfunction

  function automatic logic [SNAP_W-1:0] exp_snap();
    return pack(exp_p, exp_d, exp_q, exp_cont, exp_ar, exp_ma);
  endfunction

  task automatic exp_clear();
    exp_p = '0; exp_d = '0; exp_q = '0; exp_cont = '0;
    for (int i = 0; i < MAXO; i++) begin
      exp_ar[i] = '0;
      exp_ma[i] = '0;
    end
  endtask

  task automatic exp_req032();
    exp_clear();
    exp_p = 2; exp_d = 1; exp_q = 2; exp_cont = 32'h0;
    exp_ar[0] = 32'h0000_6000; exp_ar[1] = 32'h0000_1999;
    exp_ma[0] = 32'h0000_4000; exp_ma[1] = 32'hFFFF_E667;
  endtask

  // Present one word and hold it until accepted; returns on the negedge after
  // the handshake edge.
  task automatic send(input logic first, input logic [31:0] data);
    logic rdy;
    int   waited;
    waited = 0;
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_first = first;
    cfg_if.cfg_data  = data;
    forever begin
      rdy = cfg_if.cfg_ready;
      @(negedge clk);
      if (rdy) break;
      waited++;
      if (waited > 20) begin
        checks++; errors++;
        $display("FAIL send_timeout got=ready_low exp=ready_high data=%h", data);
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_first = 1'($urandom_range(1, 0));
    cfg_if.cfg_data  = $urandom;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_req032(input logic gaps);
    logic [31:0] words [6];
    words = '{32'hA502_0102, 32'h0, 32'h0000_6000, 32'h0000_1999, 32'h0000_4000, 32'hFFFF_E667};
    for (int i = 0; i < 6; i++) begin
      if (gaps && ($urandom_range(1, 0) == 1)) idle($urandom_range(2, 1));
      send(i == 0, words[i]);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    exp_clear();
    if (dut_snap() !== exp_snap()) begin errors++; $display("FAIL reset_outputs got=%h exp=%h", dut_snap(), exp_snap()); end
    checks++;
    if (cfg_if.cfg_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", cfg_if.cfg_ready); end
    checks++;
    if (start !== 1'b0) begin errors++; $display("FAIL reset_start got=%b exp=0", start); end
    checks++;
    if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", cfg_err); end
    checks++;
    #2 rst_n = 1'b1;
    @(negedge clk);
    if (cfg_if.cfg_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got=%b exp=1", cfg_if.cfg_ready); end
    checks++;
  endtask

  task automatic test_basic_frame();
    int hs0, st0;
    hs0 = hs_cnt; st0 = start_cnt;
    send_req032(1'b0);
    exp_req032();
    if (start !== 1'b1) begin errors++; $display("FAIL basic_start got=%b exp=1", start); end
    checks++;
    if (cfg_if.cfg_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_in_start got=%b exp=0", cfg_if.cfg_ready); end
    checks++;
    if (hs_cnt - hs0 !== 6) begin errors++; $display("FAIL basic_handshakes got=%0d exp=6", hs_cnt - hs0); end
    checks++;
    if (dut_snap() !== exp_snap()) begin errors++; $display("FAIL basic_outputs got=%h exp=%h", dut_snap(), exp_snap()); end
    checks++;
    idle(1);
    if (start !== 1'b0) begin errors++; $display("FAIL basic_start_width got=%b exp=0", start); end
    checks++;
    if (start_cnt - st0 !== 1) begin errors++; $display("FAIL basic_start_count got=%0d exp=1", start_cnt - st0); end
    checks++;
  endtask

  task automatic test_bad_header();
    logic [31:0] bad [4];
    int st0;
    bad = '{32'hA500_000B,   // p = 11
            32'h5A00_0001,   // wrong tag
            32'hA500_0401,   // d = 4
            32'hA50B_0001};  // q = 11
    st0 = start_cnt;
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 32'hA500_0001);
      if (cfg_err !== 1'b0) begin errors++; $display("FAIL bad_hdr_clear_%0d got=%b exp=0", i, cfg_err); end
      checks++;
      send(1'b1, bad[i]);
      if (cfg_err !== 1'b1) begin errors++; $display("FAIL bad_hdr_set_%0d got=%b exp=1", i, cfg_err); end
      checks++;
    end
    send(1'b0, 32'hA500_0000);
    send(1'b0, 32'h1234_5678);
    send(1'b0, 32'h0000_0000);
    idle(2);
    if (cfg_err !== 1'b1 || start_cnt != st0) begin
      errors++; $display("FAIL err_discard got=err%b/starts%0d exp=err1/starts%0d", cfg_err, start_cnt, st0);
    end
    checks++;
    exp_req032();
    if (dut_snap() !== exp_snap()) begin errors++; $display("FAIL err_outputs_held got=%h exp=%h", dut_snap(), exp_snap()); end
    checks++;
    // Empty-order frame recovers from S_ERR and commits after two words.
    send(1'b1, 32'hA500_0000);
    if (cfg_err !== 1'b0) begin errors++; $display("FAIL err_recover got=%b exp=0", cfg_err); end
    checks++;
    if (start !== 1'b0) begin errors++; $display("FAIL zero_frame_early_start got=%b exp=0", start); end
    checks++;
    send(1'b0, 32'hDEAD_BEEF);
    if (start !== 1'b1) begin errors++; $display("FAIL zero_frame_start got=%b exp=1", start); end
    checks++;
    exp_clear();
    exp_cont = 32'hDEAD_BEEF;
    if (dut_snap() !== exp_snap()) begin errors++; $display("FAIL zero_frame_outputs got=%h exp=%h", dut_snap(), exp_snap()); end
    checks++;
    idle(1);
  endtask

  task automatic test_abort();
    int st0;
    send_req032(1'b0);
    idle(1);
    st0 = start_cnt;
    send(1'b1, 32'hA500_0003);
    send(1'b0, 32'h0000_0001);
    send(1'b0, 32'h1111_1111);
    // Header arrives where AR word 1 was due.
    send(1'b1, 32'hA500_0003);
    exp_req032();
    if (start_cnt != st0) begin errors++; $display("FAIL abort_no_start got=%0d exp=%0d", start_cnt, st0); end
    checks++;
    if (dut_snap() !== exp_snap()) begin errors++; $display("FAIL abort_outputs_held got=%h exp=%h", dut_snap(), exp_snap()); end
    checks++;
    send(1'b0, 32'h0000_0002);
    send(1'b0, 32'hAAAA_0000);
    send(1'b0, 32'h0000_5555);
    send(1'b0, 32'h8000_0000);
    if (start !== 1'b1) begin errors++; $display("FAIL abort_restart_start got=%b exp=1", start); end
    checks++;
    exp_clear();
    exp_p = 3; exp_cont = 32'h2;
    exp_ar[0] = 32'hAAAA_0000; exp_ar[1] = 32'h0000_5555; exp_ar[2] = 32'h8000_0000;
    if (dut_snap() !== exp_snap()) begin errors++; $display("FAIL abort_restart_outputs got=%h exp=%h", dut_snap(), exp_snap()); end
    checks++;
    idle(1);
  endtask

  task automatic test_max_order();
    send(1'b1, 32'hA50A_030A);
    send(1'b0, 32'hCAFE_F00D);
    for (int i = 0; i < MAXO; i++) send(1'b0, 32'h1000_0000 + 32'(i));
    for (int i = 0; i < MAXO; i++) send(1'b0, 32'hF000_0000 + 32'(i * 3));
    if (start !== 1'b1) begin errors++; $display("FAIL max_order_start got=%b exp=1", start); end
    checks++;
    exp_clear();
    exp_p = 10; exp_d = 3; exp_q = 10; exp_cont = 32'hCAFE_F00D;
    for (int i = 0; i < MAXO; i++) begin
      exp_ar[i] = 32'h1000_0000 + 32'(i);
      exp_ma[i] = 32'hF000_0000 + 32'(i * 3);
    end
    if (dut_snap() !== exp_snap()) begin errors++; $display("FAIL max_order_outputs got=%h exp=%h", dut_snap(), exp_snap()); end
    checks++;
    idle(1);
  endtask

  task automatic test_gaps();
    int st0, rb0;
    st0 = start_cnt; rb0 = ready_bad;
    send_req032(1'b1);
    if (start !== 1'b1) begin errors++; $display("FAIL gaps_start got=%b exp=1", start); end
    checks++;
    idle(5);
    if (start_cnt - st0 !== 1) begin errors++; $display("FAIL gaps_start_once got=%0d exp=1", start_cnt - st0); end
    checks++;
    if (ready_bad !== 0) begin errors++; $display("FAIL gaps_ready_low got=%0d exp=0", ready_bad - rb0); end
    checks++;
    exp_req032();
    if (dut_snap() !== exp_snap()) begin errors++; $display("FAIL gaps_outputs got=%h exp=%h", dut_snap(), exp_snap()); end
    checks++;
  endtask

  task automatic test_reset_mid_frame();
    send(1'b1, 32'hA502_0102);
    send(1'b0, 32'h0);
    send(1'b0, 32'h0000_6000);
    #2 rst_n = 1'b0;
    #1;
    exp_clear();
    if (dut_snap() !== exp_snap()) begin errors++; $display("FAIL midrst_outputs got=%h exp=%h", dut_snap(), exp_snap()); end
    checks++;
    if (cfg_if.cfg_ready !== 1'b0 || start !== 1'b0 || cfg_err !== 1'b0) begin
      errors++; $display("FAIL midrst_flags got=rdy%b/start%b/err%b exp=rdy0/start0/err0", cfg_if.cfg_ready, start, cfg_err);
    end
    checks++;
    cfg_if.cfg_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    send_req032(1'b0);
    if (start !== 1'b1) begin errors++; $display("FAIL midrst_recommit_start got=%b exp=1", start); end
    checks++;
    exp_req032();
    if (dut_snap() !== exp_snap()) begin errors++; $display("FAIL midrst_recommit_outputs got=%h exp=%h", dut_snap(), exp_snap()); end
    checks++;
    idle(2);
  endtask

  initial begin
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_first = 1'b0;
    cfg_if.cfg_data  = '0;
    test_reset();
    test_basic_frame();
    test_bad_header();
    test_abort();
    test_max_order();
    test_gaps();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/arima_cfg_loader.md
ARIMA_CFG_LOADER -- requirements
Module: arima_cfg_loader

Interface
REQ-001 SHALL have parameter MAX_ORDER, default 10, the maximum AR/MA order accepted and the coefficient array depth.
REQ-002 SHALL have parameter DATA_W, default 32, the width of config words and coefficients (signed Q16.15).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 cfg_valid  input  1  config word present on cfg_data.
REQ-006 cfg_first  input  1  qualifies cfg_data as a header word when cfg_valid=1.
REQ-007 cfg_data  input  DATA_W  config word.
REQ-008 cfg_ready  output  1  loader accepts a word; a handshake is cfg_valid&cfg_ready.
REQ-009 p_order, d_order, q_order  output  32 each  committed orders.
REQ-010 cont  output  32  committed cont word.
REQ-011 ar_coef[0:MAX_ORDER-1], ma_coef[0:MAX_ORDER-1]  output  signed DATA_W  committed coefficients.
REQ-012 start  output  1  one-cycle pulse to the control unit after a commit.
REQ-013 cfg_err  output  1  sticky flag for a rejected header.

Function
REQ-014 Header word SHALL be: [7:0]=p, [15:8]=d, [23:16]=q, [31:24]=tag 8'hA5.
REQ-015 Frame SHALL be: header, then cont, then p AR coefficients (index 0 first), then q MA coefficients (index 0 first); length 2+p+q words.
REQ-016 FSM states SHALL be S_HDR, S_CONT, S_AR, S_MA, S_START, S_ERR.
REQ-017 S_HDR: a handshake with cfg_first=1 and valid header -> S_CONT; a handshake with cfg_first=0 is discarded, state unchanged.
REQ-018 Header is invalid if tag!=8'hA5, p>MAX_ORDER, q>MAX_ORDER or d>3; an invalid header -> S_ERR with cfg_err=1.
REQ-019 S_CONT -> S_AR if p>0, else S_MA if q>0, else S_START, on handshake.
REQ-020 S_AR/S_MA SHALL count accepted words with a 4-bit index; the last AR word goes to S_MA (q>0) or S_START; the last MA word goes to S_START.
REQ-021 All words SHALL load into shadow registers; shadow coefficient slots at index >= order SHALL be zeroed when the header is accepted.
REQ-022 On entry to S_START, all outputs SHALL be updated from the shadow registers on one edge, and start=1 for exactly that cycle; next state is S_HDR.
REQ-023 Latency: start SHALL be high in the cycle after the final word's handshake edge; committed outputs SHALL be stable from that cycle until the next commit.
REQ-024 cfg_ready SHALL be 1 in S_HDR, S_CONT, S_AR, S_MA and S_ERR, 0 in S_START and during reset.
REQ-025 A handshake with cfg_first=1 in any load state or in S_ERR SHALL abort the current frame (no commit) and be processed as a header in that same cycle.
REQ-026 S_ERR SHALL discard words with cfg_first=0; cfg_err SHALL clear when a valid header is accepted.
REQ-027 A failed or aborted frame SHALL leave committed outputs unchanged.
REQ-028 Coefficients SHALL pass bit-exact; no arithmetic or saturation is performed.

Reset
REQ-029 rst_n=0 SHALL immediately force S_HDR, all orders, cont and coefficients to 0, start=0, cfg_err=0, shadow registers and index to 0, including mid-frame.

Structure
REQ-030 arima_pkg SHALL hold MAX_ORDER, DATA_W, FRAC_W=15, HDR_TAG=8'hA5 and the FSM state enum typedef.
REQ-031 No sub-module; single module with FSM, index counter, shadow bank and commit bank.

Verification
REQ-032 Frame header p=2,d=1,q=2, cont=0, AR {32'h6000,32'h1999}, MA {32'h4000,32'hFFFFE667}, valid every cycle -> 6 handshakes, start pulses 1 cycle after the 6th handshake, outputs match and slots 2..9 are 0.
REQ-033 Header p=11 -> cfg_err=1 and no start; 3 following words with cfg_first=0 are discarded; then a valid p=0,d=0,q=0 frame -> cfg_err=0, start after the 2nd word.
REQ-034 Commit the frame from REQ-032, then cfg_first during the AR word 1 of a p=3 frame -> no start, outputs remain those of REQ-032, and the new frame commits normally.
REQ-035 Assert rst_n=0 after word 3 of REQ-032 -> all outputs 0 asynchronously, cfg_ready=0; after release, the full frame commits.
REQ-036 Random cfg_valid gaps (about 50%) on the REQ-032 frame -> identical committed values, start exactly once, cfg_ready=0 only in the start cycle.
